// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - push/pop valid-ready handshake bundle for ram_fifo_ctrl
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - first-word fall-through FIFO controller for a sync-write/sync-read RAM
// Optional FIFO_CTRL_ALMOST_EN adds almost_full/almost_empty flags derived from count.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_fifo_ctrl_if.slave        s,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_add_w,
    output logic [DATA_WIDTH-1:0] ram_data_w,
    output logic [ADDR_WIDTH-1:0] ram_add_r1,
    input  logic [DATA_WIDTH-1:0] ram_data_r1,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  out_valid_q;
    logic [ADDR_WIDTH:0]   stored;
    logic                  in_ready_c;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // No pass-through: a full FIFO refuses pushes even when a pop happens the same cycle.
    assign in_ready_c = ~rst & (count_q != FULL_CNT);
    assign push       = s.in_valid & in_ready_c;
    assign pop        = out_valid_q & s.out_ready;

    // Words sitting in RAM that have not yet been read out to the head register.
    assign stored = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
    assign issue  = (stored != '0) & (~out_valid_q | s.out_ready);

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = ram_data_r1;

    assign ram_we     = push;
    assign ram_add_w  = wr_ptr;
    assign ram_data_w = s.in_data;

    // When not advancing, re-read the presented head so the free-running sync read holds it.
    assign ram_add_r1 = issue ? rd_ptr : (rd_ptr - ADDR_WIDTH'(1));

    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + (ADDR_WIDTH+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (ADDR_WIDTH+1)'(1);
            end
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural 3-port RAM
module tb_ram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) tif ();

    logic          ram_we;
    logic [AW-1:0] ram_add_w;
    logic [DW-1:0] ram_data_w;
    logic [AW-1:0] ram_add_r1;
    logic [DW-1:0] ram_data_r1;
    logic [AW:0]   count;
`ifdef FIFO_CTRL_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    ram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .AF_LEVEL(4),
        .AE_LEVEL(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(tif),
        .ram_we(ram_we),
        .ram_add_w(ram_add_w),
        .ram_data_w(ram_data_w),
        .ram_add_r1(ram_add_r1),
        .ram_data_r1(ram_data_r1),
        .count(count)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full(almost_full),
        .almost_empty(almost_empty)
`endif
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_add_w] <= ram_data_w;
        ram_data_r1 <= mem[ram_add_r1];
    end

    int checks = 0;
    int errors = 0;

    // Reference: queue of unpopped words tagged with the edge that accepted them.
    // A head word is visible once at least one edge has passed since its push.
    typedef struct {
        logic [DW-1:0] data;
        int            pe;
    } ent_t;
    ent_t mq[$];
    int   edge_no = 0;

    function automatic bit model_valid();
        return (mq.size() > 0) && (mq[0].pe < edge_no);
    endfunction

    task automatic set_in(input logic v, input logic [DW-1:0] d, input logic r);
        tif.in_valid  = v;
        tif.in_data   = d;
        tif.out_ready = r;
        #1;
    endtask

    task automatic tick();
        bit mv, mpush, mpop;
        logic [DW-1:0] d;
        mv    = model_valid();
        mpush = !rst && tif.in_valid && (mq.size() < DEPTH);
        mpop  = !rst && mv && tif.out_ready;
        d     = tif.in_data;
        @(posedge clk);
        edge_no++;
        if (rst) begin
            mq.delete();
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back('{d, edge_no});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (tif.in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready: got %b expected 0", tif.in_ready);
            end
            checks++;
            if (ram_we !== 1'b0) begin
                errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we);
            end
            tick();
        end
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (tif.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", tif.out_valid);
        end
        checks++;
        if (tif.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", tif.in_ready);
        end
    endtask

    task automatic test_hold();
        set_in(1'b1, 8'h11, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (tif.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_latency: got out_valid %b expected 0", tif.out_valid);
        end
        tick();
        checks++;
        if (tif.out_valid !== 1'b1 || tif.out_data !== 8'h11) begin
            errors++; $display("FAIL hold_first: got %b/%h expected 1/11", tif.out_valid, tif.out_data);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (tif.out_valid !== 1'b1 || tif.out_data !== 8'h11) begin
                errors++; $display("FAIL hold_stable: got %b/%h expected 1/11", tif.out_valid, tif.out_data);
            end
            checks++;
            if (count !== 4'd1) begin
                errors++; $display("FAIL hold_count: got %0d expected 1", count);
            end
        end
        set_in(1'b0, 8'h00, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd0 || tif.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_pop: got %0d/%b expected 0/0", count, tif.out_valid);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'hA0 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b1, 8'hFF, 1'b0);
        checks++;
        if (count !== 4'd8 || tif.in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: got count %0d in_ready %b expected 8/0", count, tif.in_ready);
        end
        checks++;
        if (ram_we !== 1'b0) begin
            errors++; $display("FAIL fill_ninth_we: got %b expected 0", ram_we);
        end
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd8) begin
            errors++; $display("FAIL fill_ninth_count: got %0d expected 8", count);
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 8'h00, 1'b1);
            checks++;
            if (tif.out_valid !== 1'b1 || tif.out_data !== 8'hA0 + 8'(i)) begin
                errors++; $display("FAIL drain_word%0d: got %b/%h expected 1/%h", i, tif.out_valid, tif.out_data, 8'hA0 + 8'(i));
            end
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd0 || tif.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got %0d/%b expected 0/0", count, tif.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] d;
        logic          v;
        int            cyc = 0;
        while (got.size() < 20 && cyc < 60) begin
            d = 8'($urandom);
            v = (sent.size() < 20);
            set_in(v, d, 1'b1);
            if (got.size() > 0) begin
                checks++;
                if (tif.out_valid !== 1'b1) begin
                    errors++; $display("FAIL stream_bubble: got out_valid %b expected 1 at output %0d", tif.out_valid, got.size());
                end
            end
            if (v && tif.out_valid) begin
                checks++;
                if (count !== 4'd2) begin
                    errors++; $display("FAIL stream_count: got %0d expected 2", count);
                end
            end
            if (tif.out_valid === 1'b1) got.push_back(tif.out_data);
            if (v && tif.in_ready === 1'b1) sent.push_back(d);
            tick();
            cyc++;
        end
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (got.size() != 20) begin
            errors++; $display("FAIL stream_timeout: got %0d words expected 20", got.size());
        end
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++; $display("FAIL stream_word%0d: got %h expected %h", i, got[i], sent[i]);
            end
        end
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL stream_end_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_q[$];
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'h30 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b1, 8'h55, 1'b1);
        checks++;
        if (tif.in_ready !== 1'b0 || tif.out_valid !== 1'b1 || tif.out_data !== 8'h30) begin
            errors++; $display("FAIL full_simul: got in_ready %b out %b/%h expected 0 1/30", tif.in_ready, tif.out_valid, tif.out_data);
        end
        tick();
        set_in(1'b1, 8'h66, 1'b0);
        checks++;
        if (count !== 4'd7 || tif.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_after_pop: got count %0d in_ready %b expected 7/1", count, tif.in_ready);
        end
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd8) begin
            errors++; $display("FAIL full_refill: got %0d expected 8", count);
        end
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h30 + 8'(i));
        exp_q.push_back(8'h66);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 8'h00, 1'b1);
            checks++;
            if (tif.out_valid !== 1'b1 || tif.out_data !== exp_q[i]) begin
                errors++; $display("FAIL full_drain%0d: got %b/%h expected 1/%h", i, tif.out_valid, tif.out_data, exp_q[i]);
            end
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd5 || tif.out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got %0d/%b expected 5/1", count, tif.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 4'd0 || tif.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_post: got %0d/%b expected 0/0", count, tif.out_valid);
        end
`ifdef FIFO_CTRL_ALMOST_EN
        checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++; $display("FAIL almost_reset: got af %b ae %b expected 0/1", almost_full, almost_empty);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'(i), 1'b0);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL almost_at4: got af %b ae %b expected 1/1", almost_full, almost_empty);
        end
        set_in(1'b1, 8'h44, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            errors++; $display("FAIL almost_at5: got af %b ae %b expected 1/0", almost_full, almost_empty);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
`endif
    endtask

    task automatic test_random();
        logic v, r;
        bit   ev;
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 99) < ((c < 150) ? 80 : 30));
            r = ($urandom_range(0, 99) < ((c < 150) ? 30 : 80));
            set_in(v, 8'($urandom), r);
            ev = model_valid();
            checks++;
            if (count !== (AW+1)'(mq.size())) begin
                errors++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, count, mq.size());
            end
            checks++;
            if (tif.in_ready !== (mq.size() != DEPTH)) begin
                errors++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, tif.in_ready, mq.size() != DEPTH);
            end
            checks++;
            if (ram_we !== (v && mq.size() != DEPTH)) begin
                errors++; $display("FAIL rand_ram_we c%0d: got %b expected %b", c, ram_we, v && mq.size() != DEPTH);
            end
            checks++;
            if (tif.out_valid !== ev) begin
                errors++; $display("FAIL rand_out_valid c%0d: got %b expected %b", c, tif.out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (tif.out_data !== mq[0].data) begin
                    errors++; $display("FAIL rand_out_data c%0d: got %h expected %h", c, tif.out_data, mq[0].data);
                end
            end
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hold();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
